// File: rtl/key_pkg.sv
// Shared keypad types: debounce states, code width helper, default codes.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DEB,
    HELD,
    REL_DEB
  } key_state_t;

  localparam int CLR_CODE_DEF = 15;
  localparam int BS_CODE_DEF  = 14;

  // Outside every 4-bit key code; seg7 tops use it as "no key".
  localparam logic [4:0] KEY_NONE = 5'h10;

  function automatic int code_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_entry_buf.sv
// Nibble entry buffer: newest digit in [3:0], with clear and backspace keys.
module key_entry_buf
  import key_pkg::*;
#(
  parameter int DIGITS   = 6,
  parameter int CLR_CODE = CLR_CODE_DEF,
  parameter int BS_CODE  = BS_CODE_DEF,
  parameter int KW       = 4,
  localparam int CW      = code_w(DIGITS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  key_valid,
  input  logic [KW-1:0]         key_code,
  output logic [4*DIGITS-1:0]   digits,
  output logic [CW-1:0]         digit_cnt
);

  localparam logic [KW-1:0] CLR_K = KW'(CLR_CODE);
  localparam logic [KW-1:0] BS_K  = KW'(BS_CODE);
  localparam logic [CW-1:0] FULL  = CW'(DIGITS);

  logic [3:0] nib;

  assign nib = 4'(key_code);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      digits    <= '0;
      digit_cnt <= '0;
    end else if (key_valid) begin
      unique case (1'b1)
        (key_code == CLR_K): begin
          digits    <= '0;
          digit_cnt <= '0;
        end
        (key_code == BS_K): begin
          digits <= {4'h0, digits[4*DIGITS-1:4]};
          if (digit_cnt != '0)
            digit_cnt <= digit_cnt - 1'b1;
        end
        default: begin
          digits <= {digits[4*DIGITS-5:0], nib};
          if (digit_cnt != FULL)
            digit_cnt <= digit_cnt + 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_matrix_scanner.sv
// Keypad front end: column scan, frame snapshot, frame debounce, key events.
module key_matrix_scanner
  import key_pkg::*;
#(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE = 4,
  parameter int DIGITS   = 6,
  parameter int CLR_CODE = CLR_CODE_DEF,
  parameter int BS_CODE  = BS_CODE_DEF,
  localparam int KW      = code_w(ROWS * COLS),
  localparam int CW      = code_w(DIGITS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ROWS-1:0]       row,
  output logic [COLS-1:0]       col,
  output logic                  key_valid,
  output logic [KW-1:0]         key_code,
  output logic                  key_held,
  output logic [4*DIGITS-1:0]   digits,
  output logic [CW-1:0]         digit_cnt
);

  localparam int NK  = ROWS * COLS;
  localparam int DW  = code_w(SCAN_DIV);
  localparam int CIW = code_w(COLS);
  localparam int DBW = code_w(DEBOUNCE + 1);

  localparam logic [DW-1:0]  DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CIW-1:0] COL_LAST = CIW'(COLS - 1);
  localparam logic [DBW-1:0] DEB_LAST = DBW'(DEBOUNCE - 1);

  logic [ROWS-1:0] row_s1, row_s2;
  logic [DW-1:0]   div;
  logic [CIW-1:0]  cidx;
  logic [NK-1:0]   snap, frame;
  key_state_t      state;
  logic [KW-1:0]   cand, hit_code;
  logic [DBW-1:0]  cnt;
  logic            hit_one, hit_many, single, match;
  logic            last_dwell, frame_end;

  assign last_dwell = (div == DIV_LAST);
  assign frame_end  = last_dwell && (cidx == COL_LAST);

  // Snapshot with the column being captured right now merged in.
  always_comb begin
    frame = snap;
    for (int r = 0; r < ROWS; r++)
      frame[KW'(r * COLS) + KW'(cidx)] = ~row_s2[r];
  end

  always_comb begin
    hit_one  = 1'b0;
    hit_many = 1'b0;
    hit_code = '0;
    for (int i = 0; i < NK; i++) begin
      if (frame[i]) begin
        hit_many = hit_many | hit_one;
        hit_one  = 1'b1;
        hit_code = KW'(i);
      end
    end
  end

  assign single = hit_one && !hit_many;
  assign match  = single && (hit_code == cand);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_s1    <= '1;
      row_s2    <= '1;
      div       <= '0;
      cidx      <= '0;
      col       <= ~COLS'(1);
      snap      <= '0;
      state     <= IDLE;
      cand      <= '0;
      cnt       <= '0;
      key_valid <= 1'b0;
      key_code  <= '0;
      key_held  <= 1'b0;
    end else begin
      row_s1    <= row;
      row_s2    <= row_s1;
      key_valid <= 1'b0;
      div       <= last_dwell ? '0 : div + 1'b1;
      if (last_dwell) begin
        snap <= frame;
        col  <= {col[COLS-2:0], col[COLS-1]};
        cidx <= (cidx == COL_LAST) ? '0 : cidx + 1'b1;
      end
      if (frame_end) begin
        unique case (state)
          IDLE: begin
            if (single) begin
              cand <= hit_code;
              cnt  <= DBW'(1);
              if (DEBOUNCE == 1) begin
                state     <= HELD;
                key_valid <= 1'b1;
                key_code  <= hit_code;
                key_held  <= 1'b1;
              end else begin
                state <= PRESS_DEB;
              end
            end
          end
          PRESS_DEB: begin
            if (!single) begin
              state <= IDLE;
            end else if (hit_code != cand) begin
              cand <= hit_code;
              cnt  <= DBW'(1);
            end else if (cnt == DEB_LAST) begin
              state     <= HELD;
              key_valid <= 1'b1;
              key_code  <= cand;
              key_held  <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          HELD: begin
            if (!match) begin
              cnt <= DBW'(1);
              if (DEBOUNCE == 1) begin
                state    <= IDLE;
                key_held <= 1'b0;
              end else begin
                state <= REL_DEB;
              end
            end
          end
          REL_DEB: begin
            if (match) begin
              state <= HELD;
            end else if (cnt == DEB_LAST) begin
              state    <= IDLE;
              key_held <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  key_entry_buf #(
    .DIGITS   (DIGITS),
    .CLR_CODE (CLR_CODE),
    .BS_CODE  (BS_CODE),
    .KW       (KW)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_code  (key_code),
    .digits    (digits),
    .digit_cnt (digit_cnt)
  );

endmodule

// File: tb/tb_key_matrix_scanner.sv
// Bench for key_matrix_scanner: frame-level keypad plans vs a behavioural model.
module tb_key_matrix_scanner;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int SDIV = 4;
  localparam int DEB  = 3;
  localparam int NDIG = 6;
  localparam int F    = COLS * SDIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  row;
  logic [3:0]  col;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_held;
  logic [23:0] digits;
  logic [2:0]  digit_cnt;
  logic [15:0] pressed = '0;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  int obs_code[$], obs_cyc[$], exp_code[$], exp_cyc[$];
  logic [15:0] plan[$];

  bit m_held;
  int m_cand, m_run_code, m_run_len, m_miss;
  int m_dig, m_cnt, m_last;

  always #5 clk = ~clk;

  key_matrix_scanner #(
    .ROWS     (ROWS),
    .COLS     (COLS),
    .SCAN_DIV (SDIV),
    .DEBOUNCE (DEB),
    .DIGITS   (NDIG)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row       (row),
    .col       (col),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_held  (key_held),
    .digits    (digits),
    .digit_cnt (digit_cnt)
  );

  // Keypad: a pressed key shorts its row to its column while that column is low.
  always_comb begin
    row = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (pressed[r*COLS+c] && !col[c])
          row[r] = 1'b0;
  end

  always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

  always @(negedge clk)
    if (rst_n && key_valid) begin
      obs_code.push_back(int'(key_code));
      obs_cyc.push_back(cyc);
    end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: sim time limit hit, got no finish, required finish");
    $fatal(1);
  end

  function automatic int decode(input logic [15:0] m);
    int n, k;
    n = 0;
    k = -1;
    for (int i = 0; i < 16; i++)
      if (m[i]) begin
        n++;
        k = i;
      end
    return (n == 1) ? k : -1;
  endfunction

  task automatic model_reset();
    m_held = 0; m_cand = 0; m_run_code = 0; m_run_len = 0; m_miss = 0;
    m_dig = 0; m_cnt = 0; m_last = 0;
    exp_code.delete(); exp_cyc.delete();
    obs_code.delete(); obs_cyc.delete();
  endtask

  // One whole frame with a stable key set; f is the frame index since reset.
  task automatic model_frame(input logic [15:0] m, input int f);
    int d;
    d = decode(m);
    if (m_held) begin
      if (d != m_cand) begin
        m_miss++;
        if (m_miss == DEB) begin
          m_held = 0;
          m_run_len = 0;
        end
      end else begin
        m_miss = 0;
      end
    end else begin
      if (d < 0) m_run_len = 0;
      else if (m_run_len > 0 && d == m_run_code) m_run_len++;
      else begin
        m_run_code = d;
        m_run_len = 1;
      end
      if (m_run_len == DEB) begin
        m_held = 1;
        m_cand = d;
        m_miss = 0;
        m_last = d;
        exp_code.push_back(d);
        exp_cyc.push_back(F * f + F);
        if (d == 15) begin
          m_dig = 0; m_cnt = 0;
        end else if (d == 14) begin
          m_dig = m_dig >> 4;
          m_cnt = (m_cnt > 0) ? m_cnt - 1 : 0;
        end else begin
          m_dig = ((m_dig << 4) | d) & 32'h00FF_FFFF;
          m_cnt = (m_cnt < NDIG) ? m_cnt + 1 : NDIG;
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic add(input logic [15:0] m, input int n);
    repeat (n) plan.push_back(m);
  endtask

  task automatic run_plan();
    if (cyc % F != 0) begin
      model_frame(pressed, cyc / F);
      while (cyc % F != 0) @(negedge clk);
    end
    foreach (plan[i]) begin
      pressed = plan[i];
      model_frame(plan[i], cyc / F);
      repeat (F) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    plan.delete();
  endtask

  task automatic test_reset();
    pressed = '0;
    do_reset();
    vectors++;
    if ({col, key_valid, key_code, key_held, digits, digit_cnt} !==
        {4'b1110, 1'b0, 4'h0, 1'b0, 24'h0, 3'd0}) begin
      errors++;
      $display("FAIL reset_vals: got col=%b kv=%b code=%h held=%b dig=%h cnt=%0d",
               col, key_valid, key_code, key_held, digits, digit_cnt);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (col !== 4'b1110) begin
      errors++;
      $display("FAIL col_dwell: got %b, required 1110", col);
    end
    @(negedge clk);
    vectors++;
    if (col !== 4'b1101) begin
      errors++;
      $display("FAIL col_step: got %b, required 1101", col);
    end
    repeat (12) @(negedge clk);
    vectors++;
    if (col !== 4'b1110) begin
      errors++;
      $display("FAIL col_wrap: got %b, required 1110", col);
    end
  endtask

  task automatic test_single_press();
    pressed = '0;
    do_reset();
    add(16'h1 << 6, 5);
    run_plan();
    vectors++;
    if (obs_code.size() !== 1) begin
      errors++;
      $display("FAIL single_count: got %0d events, required 1", obs_code.size());
    end
    if (obs_code.size() > 0) begin
      vectors++;
      if (obs_code[0] !== 6 || obs_cyc[0] !== 48) begin
        errors++;
        $display("FAIL single_event: got code %0d at cycle %0d, required 6 at 48",
                 obs_code[0], obs_cyc[0]);
      end
    end
    vectors++;
    if (digits[3:0] !== 4'h6 || digit_cnt !== 3'd1 || key_held !== 1'b1 || key_code !== 4'h6) begin
      errors++;
      $display("FAIL single_state: got dig0=%h cnt=%0d held=%b code=%h, required 6 1 1 6",
               digits[3:0], digit_cnt, key_held, key_code);
    end
  endtask

  task automatic test_bounce();
    pressed = '0;
    do_reset();
    add(16'h1 << 9, 2);
    add(16'h0, 1);
    add(16'h1 << 9, 5);
    run_plan();
    vectors++;
    if (obs_code.size() !== 1) begin
      errors++;
      $display("FAIL bounce_count: got %0d events, required 1", obs_code.size());
    end
    if (obs_code.size() > 0) begin
      vectors++;
      if (obs_code[0] !== 9 || obs_cyc[0] !== 96) begin
        errors++;
        $display("FAIL bounce_event: got code %0d at cycle %0d, required 9 at 96",
                 obs_code[0], obs_cyc[0]);
      end
    end
  endtask

  task automatic test_sequence();
    pressed = '0;
    do_reset();
    for (int k = 1; k <= 7; k++) begin
      add(16'h1 << k, 3);
      add(16'h0, 3);
    end
    run_plan();
    vectors++;
    if (digits !== 24'h234567 || digit_cnt !== 3'd6) begin
      errors++;
      $display("FAIL seq_buffer: got %h cnt %0d, required 234567 cnt 6", digits, digit_cnt);
    end
    vectors++;
    if (obs_code.size() !== 7 || key_held !== 1'b0) begin
      errors++;
      $display("FAIL seq_events: got %0d events held=%b, required 7 held=0",
               obs_code.size(), key_held);
    end
  endtask

  task automatic test_backspace_clear();
    int keys[4];
    keys = '{1, 2, 3, 14};
    pressed = '0;
    do_reset();
    foreach (keys[i]) begin
      add(16'h1 << keys[i], 3);
      add(16'h0, 3);
    end
    run_plan();
    vectors++;
    if (digits !== 24'h000012 || digit_cnt !== 3'd2 || key_code !== 4'he) begin
      errors++;
      $display("FAIL backspace: got %h cnt %0d code %h, required 000012 cnt 2 code e",
               digits, digit_cnt, key_code);
    end
    add(16'h1 << 15, 3);
    add(16'h0, 3);
    run_plan();
    vectors++;
    if (digits !== 24'h0 || digit_cnt !== 3'd0 || key_code !== 4'hf) begin
      errors++;
      $display("FAIL clear: got %h cnt %0d code %h, required 0 cnt 0 code f",
               digits, digit_cnt, key_code);
    end
  endtask

  task automatic test_multi_press();
    pressed = '0;
    do_reset();
    add(16'h0021, 5);
    run_plan();
    vectors++;
    if (obs_code.size() !== 0 || key_held !== 1'b0) begin
      errors++;
      $display("FAIL multi_reject: got %0d events held=%b, required 0 held=0",
               obs_code.size(), key_held);
    end
    add(16'h0001, 4);
    run_plan();
    vectors++;
    if (obs_code.size() !== 1 || key_held !== 1'b1 || key_code !== 4'h0) begin
      errors++;
      $display("FAIL multi_release: got %0d events held=%b code=%h, required 1 1 0",
               obs_code.size(), key_held, key_code);
    end
  endtask

  task automatic test_reset_held();
    pressed = '0;
    do_reset();
    add(16'h1 << 5, 5);
    run_plan();
    vectors++;
    if (key_held !== 1'b1 || key_code !== 4'h5) begin
      errors++;
      $display("FAIL rh_held: got held=%b code=%h, required 1 5", key_held, key_code);
    end
    do_reset();
    vectors++;
    if ({col, key_valid, key_code, key_held, digits, digit_cnt} !==
        {4'b1110, 1'b0, 4'h0, 1'b0, 24'h0, 3'd0}) begin
      errors++;
      $display("FAIL rh_reset: got col=%b kv=%b code=%h held=%b dig=%h cnt=%0d",
               col, key_valid, key_code, key_held, digits, digit_cnt);
    end
    add(16'h1 << 5, 2);
    run_plan();
    vectors++;
    if (obs_code.size() !== 0 || key_held !== 1'b0) begin
      errors++;
      $display("FAIL rh_early: got %0d events held=%b, required 0 held=0",
               obs_code.size(), key_held);
    end
    add(16'h1 << 5, 2);
    run_plan();
    vectors++;
    if (obs_code.size() !== 1) begin
      errors++;
      $display("FAIL rh_count: got %0d events, required 1", obs_code.size());
    end
    if (obs_code.size() > 0) begin
      vectors++;
      if (obs_code[0] !== 5 || obs_cyc[0] !== 48) begin
        errors++;
        $display("FAIL rh_event: got code %0d at cycle %0d, required 5 at 48",
                 obs_code[0], obs_cyc[0]);
      end
    end
  endtask

  task automatic test_random();
    int sel, k;
    logic [15:0] m;
    pressed = '0;
    do_reset();
    for (int it = 0; it < 10; it++) begin
      repeat ($urandom_range(3, 8)) begin
        sel = $urandom_range(0, 9);
        m = '0;
        if (sel >= 2) begin
          k = $urandom_range(0, 15);
          m = m | (16'h1 << k);
        end
        if (sel >= 8) begin
          k = $urandom_range(0, 15);
          m = m | (16'h1 << k);
        end
        add(m, $urandom_range(1, 5));
      end
      run_plan();
      vectors++;
      if (obs_code.size() !== exp_code.size()) begin
        errors++;
        $display("FAIL rnd_count it%0d: got %0d events, required %0d",
                 it, obs_code.size(), exp_code.size());
      end
      for (int i = 0; i < obs_code.size() && i < exp_code.size(); i++) begin
        vectors++;
        if (obs_code[i] !== exp_code[i] || obs_cyc[i] !== exp_cyc[i]) begin
          errors++;
          $display("FAIL rnd_event it%0d #%0d: got %0d@%0d, required %0d@%0d",
                   it, i, obs_code[i], obs_cyc[i], exp_code[i], exp_cyc[i]);
        end
      end
      vectors++;
      if (digits !== 24'(m_dig) || digit_cnt !== 3'(m_cnt) ||
          key_held !== m_held || key_code !== 4'(m_last)) begin
        errors++;
        $display("FAIL rnd_state it%0d: got %h/%0d/%b/%h, required %h/%0d/%b/%h",
                 it, digits, digit_cnt, key_held, key_code,
                 24'(m_dig), m_cnt, m_held, 4'(m_last));
      end
      obs_code.delete(); obs_cyc.delete();
      exp_code.delete(); exp_cyc.delete();
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_sequence();
    test_backspace_clear();
    test_multi_press();
    test_reset_held();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
